// File: rtl/byte_word_pkg.sv
// Shared types and lane-placement helper for the byte-to-word assembler.
package byte_word_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    LITTLE = 1'b0,
    BIG    = 1'b1
  } endian_e;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_HOLD  = 1'b1
  } hold_state_e;

  // Lane that the k-th byte of an n-byte word occupies.
  function automatic int lane_idx(input int k, input int n, input endian_e big);
    return (big == BIG) ? (n - 1 - k) : k;
  endfunction

endpackage

// File: rtl/byte_word_assembler_hold.sv
// Output holding register: keeps a closed word stable until the consumer takes it.
module word_hold_reg
  import byte_word_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         load,
  input  logic [W-1:0] load_data,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  hold_state_e state;

  // A load may coincide with the drain of the previous word; the load wins.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state       <= S_EMPTY;
      out_payload <= '0;
    end else if (load) begin
      state       <= S_HOLD;
      out_payload <= load_data;
    end else if (state == S_HOLD && out_ready) begin
      state <= S_EMPTY;
    end
  end

  assign out_valid = (state == S_HOLD);
  assign in_ready  = !out_valid || out_ready;

endmodule

// File: rtl/byte_word_assembler.sv
// Reassembles a byte stream into WORD_BYTES-wide words, little- or big-endian.
module byte_word_assembler
  import byte_word_pkg::*;
#(
  parameter int WORD_BYTES = 4,
  parameter int BIG_ENDIAN = 0,
  parameter int CNT_W      = $clog2(WORD_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    reset_l,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  byte_t                   in_data,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [8*WORD_BYTES-1:0] out_data,
  output logic [CNT_W-1:0]        out_bytes,
  output logic                    out_short
);

  localparam int      DATA_W = 8 * WORD_BYTES;
  localparam int      PAY_W  = 1 + CNT_W + DATA_W;
  localparam endian_e ENDIAN = (BIG_ENDIAN != 0) ? BIG : LITTLE;

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] merged;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  next_cnt;
  logic              in_xfer;
  logic              full;
  logic              closing;
  logic              short_word;
  logic [PAY_W-1:0]  payload;

  // A transfer on either side happens on a posedge where valid and ready are both high;
  // in_ready depends only on the output stage, never on in_valid.
  assign in_xfer    = in_valid && in_ready;
  assign next_cnt   = cnt + CNT_W'(1);
  assign full       = (next_cnt == CNT_W'(WORD_BYTES));
  assign closing    = in_xfer && (full || in_last);
  assign short_word = in_last && !full;

  always_comb begin
    merged = acc;
    for (int l = 0; l < WORD_BYTES; l++) begin
      if (l == lane_idx(int'(cnt), WORD_BYTES, ENDIAN)) begin
        merged[8*l +: 8] = in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      acc <= '0;
      cnt <= '0;
    end else if (in_xfer) begin
      if (full || in_last) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= merged;
        cnt <= next_cnt;
      end
    end
  end

  word_hold_reg #(
    .W(PAY_W)
  ) u_hold (
    .clk        (clk),
    .reset_l    (reset_l),
    .load       (closing),
    .load_data  ({short_word, next_cnt, merged}),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_payload(payload)
  );

  assign {out_short, out_bytes, out_data} = payload;

endmodule

// File: tb/tb_byte_word_assembler.sv
// Bench for byte_word_assembler: one little-endian and one big-endian instance.
module tb_byte_word_assembler;

  localparam int WB = 4;
  localparam int CW = 3;
  localparam int DW = 8 * WB;
  localparam int PW = 1 + CW + DW;

  logic          clk = 1'b0;
  logic          reset_l = 1'b0;
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [7:0]    in_data   [2];
  logic          in_last   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [DW-1:0] out_data  [2];
  logic [CW-1:0] out_bytes [2];
  logic          out_short [2];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [PW-1:0] exp_q [2][$];
  int            part_n [2];
  logic [DW-1:0] part_w [2];

  byte_word_assembler #(.WORD_BYTES(WB), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .reset_l(reset_l),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]), .in_last(in_last[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_bytes(out_bytes[0]), .out_short(out_short[0])
  );

  byte_word_assembler #(.WORD_BYTES(WB), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .reset_l(reset_l),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]), .in_last(in_last[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_bytes(out_bytes[1]), .out_short(out_short[1])
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int i, input logic [63:0] act,
                              input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", name, i, act, exp);
    end
  endfunction

  // Model: bytes accumulate arithmetically into a word; closed words queue up
  // and must appear on the output one cycle later, in order, until consumed.
  always @(negedge clk) begin
    int lane;
    for (int i = 0; i < 2; i++) begin
      if (!reset_l) begin
        exp_q[i].delete();
        part_n[i] = 0;
        part_w[i] = '0;
      end else begin
        chk("in_ready_rule", i, 64'(in_ready[i]), 64'(!out_valid[i] || out_ready[i]));
        chk("out_valid_pending", i, 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
        if (out_valid[i] && exp_q[i].size() != 0) begin
          chk("word", i, 64'({out_short[i], out_bytes[i], out_data[i]}), 64'(exp_q[i][0]));
          if (out_ready[i]) void'(exp_q[i].pop_front());
        end
        if (in_valid[i] && in_ready[i]) begin
          lane = (i == 1) ? (WB - 1 - part_n[i]) : part_n[i];
          part_w[i] = part_w[i] | (DW'(in_data[i]) << (8 * lane));
          part_n[i]++;
          if (part_n[i] == WB || in_last[i]) begin
            exp_q[i].push_back({(in_last[i] && part_n[i] < WB), CW'(part_n[i]), part_w[i]});
            part_n[i] = 0;
            part_w[i] = '0;
          end
        end
      end
    end
  end

  // driver tasks: all run in the phase just after a posedge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d, input logic last);
    logic ok;
    in_valid[i] = 1'b1;
    in_data[i]  = d;
    in_last[i]  = last;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready[i];
      @(posedge clk);
      #1;
    end
    in_valid[i] = 1'b0;
    in_last[i]  = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout dut%0d: byte %0h not accepted, required within 40 cycles", i, d);
    end
  endtask

  // Sends n bytes taken from w starting at bits [7:0]; in_last on the final one if last.
  task automatic send_seq(input int i, input logic [31:0] w, input int n, input logic last);
    for (int k = 0; k < n; k++) begin
      send(i, w[8*k +: 8], last && (k == n - 1));
    end
  endtask

  task automatic expect_out(input int i, input string name, input logic v,
                            input logic [DW-1:0] d, input logic [CW-1:0] nb, input logic sh);
    chk({name, "_valid"}, i, 64'(out_valid[i]), 64'(v));
    chk({name, "_data"},  i, 64'(out_data[i]),  64'(d));
    chk({name, "_bytes"}, i, 64'(out_bytes[i]), 64'(nb));
    chk({name, "_short"}, i, 64'(out_short[i]), 64'(sh));
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded 200000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    int t0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_data[i]   = 8'h00;
      in_last[i]   = 1'b0;
      out_ready[i] = 1'b1;
    end
    reset_l = 1'b0;
    tick(3);
    reset_l = 1'b1;
    for (int i = 0; i < 2; i++) begin
      expect_out(i, "reset", 1'b0, '0, '0, 1'b0);
      chk("reset_in_ready", i, 64'(in_ready[i]), 64'd1);
    end
    tick(1);

    // little-endian full word
    send_seq(0, 32'hDEADBEEF, 4, 1'b0);
    expect_out(0, "le_full", 1'b1, 32'hDEADBEEF, 3'd4, 1'b0);
    tick(2);

    // big-endian, two words back to back
    t0 = cyc;
    send_seq(1, 32'hDEADBEEF, 4, 1'b0);
    expect_out(1, "be_first", 1'b1, 32'hEFBEADDE, 3'd4, 1'b0);
    send_seq(1, 32'hFEEDFACE, 4, 1'b0);
    expect_out(1, "be_second", 1'b1, 32'hCEFAEDFE, 3'd4, 1'b0);
    chk("be_back_to_back_cycles", 1, 64'(cyc - t0), 64'd8);
    tick(2);

    // short words in both byte orders
    send_seq(1, 32'h00002211, 2, 1'b1);
    expect_out(1, "be_short", 1'b1, 32'h11220000, 3'd2, 1'b1);
    send_seq(0, 32'h00002211, 2, 1'b1);
    expect_out(0, "le_short", 1'b1, 32'h00002211, 3'd2, 1'b1);
    send_seq(0, 32'h66554433, 4, 1'b0);
    expect_out(0, "le_after_short", 1'b1, 32'h66554433, 3'd4, 1'b0);
    tick(2);

    // backpressure: hold word 1, then release while word 2 is pending
    out_ready[0] = 1'b0;
    send_seq(0, 32'hDEADBEEF, 4, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk("bp_in_ready", 0, 64'(in_ready[0]), 64'd0);
      chk("bp_hold_data", 0, 64'(out_data[0]), 64'hDEADBEEF);
    end
    fork
      send_seq(0, 32'h04030201, 4, 1'b0);
      begin
        tick(2);
        out_ready[0] = 1'b1;
      end
    join
    expect_out(0, "bp_second", 1'b1, 32'h04030201, 3'd4, 1'b0);
    tick(2);

    // reset in the middle of a word
    send_seq(0, 32'h0000BBAA, 2, 1'b0);
    reset_l = 1'b0;
    tick(1);
    reset_l = 1'b1;
    expect_out(0, "mid_reset", 1'b0, '0, '0, 1'b0);
    send_seq(0, 32'h04030201, 4, 1'b0);
    expect_out(0, "after_reset", 1'b1, 32'h04030201, 3'd4, 1'b0);
    tick(2);

    // same-cycle drain and close, then in_last on the final lane
    send_seq(0, 32'h00000001, 1, 1'b1);
    expect_out(0, "swap_first", 1'b1, 32'h00000001, 3'd1, 1'b1);
    t0 = cyc;
    send_seq(0, 32'h00000002, 1, 1'b1);
    chk("swap_cycles", 0, 64'(cyc - t0), 64'd1);
    expect_out(0, "swap_second", 1'b1, 32'h00000002, 3'd1, 1'b1);
    send_seq(0, 32'h0D0C0B0A, 4, 1'b1);
    expect_out(0, "last_on_full", 1'b1, 32'h0D0C0B0A, 3'd4, 1'b0);
    tick(4);

    for (int i = 0; i < 2; i++) begin
      chk("drained", i, 64'(exp_q[i].size()), 64'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
